// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered operand/issue stage feeding the 32-bit ALU.
// Decodes ALUOp/Funct into the ALU control code, resolves Rs/Rt with
// EX/MEM and MEM/WB forwarding, and selects the immediate operand.
// The result sits in a single-entry output register with a valid/ready
// handshake.
// Ports:
//   Clk, Rst (sync, active high), Flush
//   InValid/InReady             upstream handshake
//   ALUOp, Funct, ALUSrc, Imm   decode inputs
//   RsAddr/RtAddr/RsData/RtData register operands
//   RegWriteIn, WriteRegIn      destination info
//   ExMem*/MemWb*               forwarding sources
//   OutValid/OutReady           downstream handshake
//   ALUControl, A, B, RegWriteOut, WriteRegOut, Illegal  registered outputs
module alu_operand_stage #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic             ALUSrc,
    input  logic [15:0]      Imm,
    input  logic [4:0]       RsAddr,
    input  logic [4:0]       RtAddr,
    input  logic [WIDTH-1:0] RsData,
    input  logic [WIDTH-1:0] RtData,
    input  logic             RegWriteIn,
    input  logic [4:0]       WriteRegIn,
    input  logic             ExMemRegWrite,
    input  logic             MemWbRegWrite,
    input  logic [4:0]       ExMemWriteReg,
    input  logic [4:0]       MemWbWriteReg,
    input  logic [WIDTH-1:0] ExMemResult,
    input  logic [WIDTH-1:0] MemWbResult,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             RegWriteOut,
    output logic [4:0]       WriteRegOut,
    output logic             Illegal
);

    logic             valid_q;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rw_q, rw_d;
    logic [4:0]       wr_q;
    logic             ill_q, ill_d;
    logic             capture;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] rt_fwd;

    assign InReady = !Rst && !Flush && (!valid_q || OutReady);
    assign capture = InValid && InReady;

    // EX/MEM wins over MEM/WB; r0 is hardwired and never forwarded.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [4:0]       addr,
        input logic [WIDTH-1:0] rf
    );
        if (addr != 5'd0 && ExMemRegWrite && ExMemWriteReg == addr)
            return ExMemResult;
        else if (addr != 5'd0 && MemWbRegWrite && MemWbWriteReg == addr)
            return MemWbResult;
        else
            return rf;
    endfunction

    always_comb begin
        ctrl_d = 3'd2;
        ill_d  = 1'b0;
        unique case (ALUOp)
            2'b00: ctrl_d = 3'd2;
            2'b01: ctrl_d = 3'd6;
            2'b11: ctrl_d = 3'd1;
            2'b10: begin
                unique case (Funct)
                    6'b100100: ctrl_d = 3'd0;
                    6'b100101: ctrl_d = 3'd1;
                    6'b100000: ctrl_d = 3'd2;
                    6'b100010: ctrl_d = 3'd6;
                    6'b101010: ctrl_d = 3'd7;
                    default: begin
                        ctrl_d = 3'd2;
                        ill_d  = 1'b1;
                    end
                endcase
            end
            default: ctrl_d = 3'd2;
        endcase
    end

    // ori takes a zero-extended immediate; everything else sign-extends.
    always_comb begin
        if (ALUOp == 2'b11)
            imm_ext = {{(WIDTH-16){1'b0}}, Imm};
        else
            imm_ext = {{(WIDTH-16){Imm[15]}}, Imm};
    end

    assign rt_fwd = fwd(RtAddr, RtData);
    assign a_d    = fwd(RsAddr, RsData);
    assign b_d    = ALUSrc ? imm_ext : rt_fwd;
    assign rw_d   = RegWriteIn && !ill_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            rw_q    <= 1'b0;
            wr_q    <= 5'd0;
            ill_q   <= 1'b0;
        end else if (Flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rw_q    <= rw_d;
            wr_q    <= WriteRegIn;
            ill_q   <= ill_d;
        end else if (valid_q && OutReady) begin
            valid_q <= 1'b0;
        end
    end

    assign OutValid    = valid_q;
    assign ALUControl  = ctrl_q;
    assign A           = a_q;
    assign B           = b_q;
    assign RegWriteOut = rw_q;
    assign WriteRegOut = wr_q;
    assign Illegal     = ill_q;

endmodule
